// File: rtl/dezigzag_pkg.sv
// Shared constants for the inverse-zigzag reorder buffer: block geometry and
// the standard JPEG zigzag-to-raster index map.
package dezigzag_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(BLK_SIZE - 1);

  // Entry k is the raster position of the k-th coefficient in zigzag order.
  localparam idx_t ZZ_TO_RASTER [0:BLK_SIZE-1] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic idx_t zz_to_raster(input idx_t zz);
    return ZZ_TO_RASTER[zz];
  endfunction

endpackage

// File: rtl/dezigzag_bank.sv
// One 64-entry coefficient bank: synchronous write, asynchronous read.
// Contents are deliberately not reset; validity is tracked by the owner's flags.
module dezigzag_bank
  import dezigzag_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  idx_t              waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  idx_t              raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [BLK_SIZE];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dezigzag_buf.sv
// Ping-pong inverse-zigzag buffer: zigzag-ordered samples in, raster-ordered out.
// Optional status outputs (blk_done, blk_cnt) when DEZIGZAG_STATUS_EN is defined.
module dezigzag_buf
  import dezigzag_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef DEZIGZAG_STATUS_EN
  ,
  output logic              blk_done,
  output logic [15:0]       blk_cnt
`endif
);

  logic [1:0]        full_q, full_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  idx_t              wr_cnt_q, wr_cnt_d;
  idx_t              rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;

  logic              wr_fire, wr_end;
  logic              adv, rd_fire, rd_end;
  idx_t              wr_addr;
  logic [1:0]        bank_we;
  logic [DATA_W-1:0] bank_rdata [2];
  logic [DATA_W-1:0] rd_data;

  // Readiness depends only on registered flags, never on in_valid.
  assign in_ready = !full_q[wsel_q];
  assign wr_fire  = in_valid && in_ready;
  assign wr_end   = (wr_cnt_q == LAST_IDX);
  assign wr_addr  = zz_to_raster(wr_cnt_q);
  assign bank_we  = {wr_fire & wsel_q, wr_fire & ~wsel_q};

  assign adv      = !out_valid_q || out_ready;
  assign rd_fire  = adv && full_q[rsel_q];
  assign rd_end   = (rd_cnt_q == LAST_IDX);
  assign rd_data  = bank_rdata[rsel_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dezigzag_bank #(.DATA_W(DATA_W)) u_bank (
      .clk     (clk),
      .we_i    (bank_we[b]),
      .waddr_i (wr_addr),
      .wdata_i (in_data),
      .raddr_i (rd_cnt_q),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    wsel_d   = wsel_q;
    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + idx_t'(1);
      if (wr_end) begin
        wsel_d = ~wsel_q;
      end
    end
  end

  // Set and clear always target different banks, so both may apply together.
  always_comb begin
    full_d = full_q;
    if (wr_fire && wr_end) begin
      full_d[wsel_q] = 1'b1;
    end
    if (rd_fire && rd_end) begin
      full_d[rsel_q] = 1'b0;
    end
  end

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    rsel_d      = rsel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (adv) begin
      if (full_q[rsel_q]) begin
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
        out_last_d  = rd_end;
        rd_cnt_d    = rd_cnt_q + idx_t'(1);
        if (rd_end) begin
          rsel_d = ~rsel_q;
        end
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= '0;
      wsel_q      <= 1'b0;
      rsel_q      <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      wsel_q      <= wsel_d;
      rsel_q      <= rsel_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef DEZIGZAG_STATUS_EN
  logic        blk_hs;
  logic [15:0] blk_cnt_q, blk_cnt_d;

  assign blk_hs    = out_valid_q && out_ready && out_last_q;
  assign blk_done  = blk_hs && !rst;
  assign blk_cnt_d = blk_hs ? blk_cnt_q + 16'd1 : blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: doc/dezigzag_buf.md
Name: dezigzag_buf

Overview:
- Decoder-side inverse-zigzag reorder buffer for the JPEG path; the counterpart of the encoder's zigzag stage.
- Accepts 8x8 coefficient blocks serially in zigzag order, 64 samples per block.
- Re-emits each block in raster order, row-major, for the IDCT input.
- Ping-pong double buffer, so one block is written while the previous block is read. Sustains 1 sample/cycle on both sides.

Parameters:
- DATA_W, 8, sample width in bits.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  coefficient in zigzag order.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  buffer can accept a sample.
- out_data  output  DATA_W  coefficient in raster order.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high with raster index 63 of a block.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0. Both bank full flags=0, wsel=0, rsel=0, wr_cnt=0, rd_cnt=0. in_ready=1 in the first cycle after reset.
- Reset mid-block discards all partial and full banks. No output follows until 64 new samples are accepted.
- Write side:
  - A sample is accepted when in_valid && in_ready. It is stored at bank[wsel][ZZ_TO_RASTER[wr_cnt]], then wr_cnt increments.
  - in_ready = !full[wsel]. It is combinational from registered flags only, with no path from in_valid.
  - When the sample at wr_cnt==63 is accepted: full[wsel] sets, wsel toggles, wr_cnt wraps to 0.
- Read side:
  - Output register advance condition: adv = !out_valid || out_ready.
  - If adv && full[rsel]: out_data <= bank[rsel][rd_cnt], out_valid <= 1, out_last <= (rd_cnt==63), then rd_cnt increments.
  - When rd_cnt==63 is loaded: full[rsel] clears, rsel toggles, rd_cnt wraps to 0.
  - If adv && !full[rsel]: out_valid <= 0, out_last <= 0, out_data holds.
- Latency: the 64th sample is accepted at edge N, which sets full. The first raster sample is loaded at edge N+1. out_valid is high in the cycle after N+1.
- Backpressure: while out_valid && !out_ready, out_data, out_last and rd_cnt hold.
- Simultaneous events:
  - A set of full[a] from the write side and a clear of full[b] from the read side in the same cycle both take effect.
  - a==b cannot occur, because writes are blocked while a bank is full.
- Both banks full: in_ready=0 until the read side loads raster index 63 of bank rsel. in_ready returns in the next cycle.
- Bank storage is not reset; only the flags and counters are.

Optional Feature:
- Macro: DEZIGZAG_STATUS_EN.
- When defined, adds two output ports:
  - blk_done (1 bit): a one-cycle pulse on the cycle an out_valid && out_ready handshake occurs with out_last=1.
  - blk_cnt (16 bits): counts completed output blocks, wraps 65535->0, reset value 0.
- blk_done resets to 0.
- When not defined, these ports and their logic are absent; everything else is identical.

Decomposition:
- Package dezigzag_pkg holds:
  - BLK_SIZE=64 and IDX_W=6.
  - The constant table ZZ_TO_RASTER[0:63], standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 61,54,47,55,62,63.
- Sub-module dezigzag_bank: one 64 x DATA_W register file with one synchronous write port and one asynchronous read port, instantiated twice.
- Control (flags, counters, output register) stays in the top module.

Test Plan:
- Single block, in_data=zigzag index 0..63, out_ready=1:
  - Raster output equals the inverse table, e.g. outputs 0..5 are 0,1,5,6,14,15; output 63 is 63.
  - out_last is high only on output 63.
  - First out_valid appears 2 edges after the 64th accept.
- Four back-to-back blocks, in_valid=1, out_ready=1:
  - in_ready never drops.
  - 256 outputs, each block's data correct (block k data = k*64 + zigzag index, mod 256 at DATA_W=8).
  - Outputs are gapless after the first block.
- out_ready=0 held while feeding 3 blocks:
  - in_ready drops after 128 accepts.
  - out_data/out_last are stable while stalled.
  - Releasing out_ready drains correctly.
  - in_ready rises the cycle after raster 63 of block 0 is loaded.
- Random in_valid/out_ready toggling (50%) over 100 blocks: the scoreboard matches the reference remap with no loss or duplication.
- Assert rst after 30 samples of a block: next cycle out_valid=0, in_ready=1. A fresh 64-sample block then emerges correctly.
- DEZIGZAG_STATUS_EN defined, 3 blocks: blk_done pulses 3 times and blk_cnt=3. Preload via force to 65535 and complete one block: blk_cnt=0.
